load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller for the 32-bit word-organised data memory. Accepts byte/halfword/word load and store requests from the core, one at a time. Converts byte addresses to word addresses and aligns and sign-extends load data. The memory has no byte enables, so sub-word stores are implemented as read-modify-write. Sits between the core's execute stage and the memory block.

## Interface
- READ_LATENCY, 2, cycles from the cycle mem_addr is presented (we low) to the cycle mem_data_out is valid; legal range 1..4.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  core request present
- req_ready  output  1  high only in IDLE; request accepted on edge where req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: zero-extend instead of sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse; no back-pressure
- resp_error  output  1  valid with resp_valid; illegal size (or misaligned, see Configuration)
- resp_rdata  output  32  load result; 0 for stores and errors
- mem_write_enable  output  1  memory write strobe
- mem_addr  output  32  word address, {2'b00, addr[31:2]}
- mem_data_in  output  32  write data to memory
- mem_data_out  input  32  read data from memory

## Operation
- Capture all req_* fields on acceptance; single outstanding request.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- Transitions from IDLE on acceptance:
  - Load, or sub-word store: go to READ.
  - Word store: go to WRITE.
  - Error request: go to DONE.
- READ: one cycle, mem_addr driven, we=0, then WAIT.
- WAIT: READ_LATENCY cycles via down-counter. mem_data_out is captured on the last WAIT cycle. Then WRITE for a sub-word store, or DONE for a load.
- WRITE: one cycle, mem_write_enable=1, then DONE.
  - Word store: mem_data_in = req_wdata.
  - Sub-word store: mem_data_in = captured word with the target lane replaced.
- DONE: resp_valid=1 for one cycle, then IDLE.
- Lanes are little-endian.
  - Byte lane = addr[1:0], i.e. bits [8*lane+7 : 8*lane].
  - Half lane = addr[1].
- Load extraction: shift the selected lane to bit 0, then sign- or zero-extend to 32 bits. Word loads pass through unchanged.
- mem_addr holds stable from READ through WRITE. mem_data_in is 0 outside WRITE.
- mem_write_enable = (state == WRITE) && !reset. A reset in the WRITE cycle suppresses the write.
- Reset at any point: state goes to IDLE, outputs go to 0, and the in-flight request is dropped with no response.

## Timing
- Reset values: req_ready=0 during reset and 1 the cycle after; all other outputs 0.
- Request accepted at the edge ending cycle A. With READ_LATENCY=2:
  - Load: READ in A+1; WAIT in A+2 and A+3; resp_valid in A+4.
  - Word store: write in A+1; resp_valid in A+2.
  - Sub-word store: READ in A+1; write in A+4; resp_valid in A+5.
  - Error: resp_valid in A+1; no memory activity.
- Generally, load response arrives at A+2+READ_LATENCY.
- req_ready is 0 from A+1 through the DONE cycle. The next acceptance is possible at the earliest in the cycle after DONE.
- req_valid while req_ready=0 is ignored. The core must hold the request.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is an error.
  - Error path: straight to DONE, resp_error=1, no memory access.
- Undefined:
  - Misaligned low bits are forced to natural alignment: half ignores addr[0], word ignores addr[1:0].
  - The access proceeds normally.
- size 11 is an error in both builds.

## Structure
- Package lsu_pkg holds:
  - lsu_size_e (BYTE, HALF, WORD, ILLEGAL)
  - lsu_state_e (IDLE, READ, WAIT, WRITE, DONE)
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_byte_lane, purely combinational:
  - Load extract/extend from (word, addr[1:0], size, unsigned).
  - Store merge from (old word, wdata, addr[1:0], size).
- Top level holds only the FSM, counter and registers.

## Test plan
- Word store then load: store addr 0x10, data 0xDEADBEEF. Expect mem_addr=0x4 with we=1 in A+1 and resp in A+2. Load addr 0x10 returns 0xDEADBEEF in A+4.
- Byte signed/unsigned load: word 0x80FF7F01 at 0x20.
  - lb 0x21 -> 0x0000007F
  - lb 0x22 -> 0xFFFFFFFF
  - lbu 0x23 -> 0x00000080
  - lh 0x22 -> 0xFFFF80FF
- Sub-word store RMW: word 0x11223344 at 0x30; sb 0x31 with data 0xAA.
  - Expect exactly one we pulse, in A+4, with mem_data_in=0x1122AA44.
  - resp in A+5.
  - sh 0x32 with data 0xBEEF then gives 0xBEEFAA44.
- Error path: size=11 -> resp_error=1 in A+1 with no we. With LSU_MISALIGN_TRAP_EN, lw 0x41 -> error. Without it, lw 0x41 reads word 0x40.
- Reset mid-operation:
  - Reset asserted in the WRITE cycle of an sb: no write occurs, no resp, req_ready=1 the cycle after reset deasserts.
  - Reset during WAIT: no resp.
- Back-to-back: req_valid held high with two loads. Second acceptance lands exactly one cycle after the first's resp_valid; req_ready=0 throughout.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, captured request payload.
// LSU_MISALIGN_TRAP_EN selects trapping of misaligned half/word accesses.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } lsu_state_e;

  typedef struct packed {
    logic            write;
    lsu_size_e       size;
    logic            zext;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // True when the access does not sit on its natural boundary
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      HALF:    return addr_lo[0];
      WORD:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory signals of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_error;
  logic [XLEN-1:0] resp_rdata;
  logic            mem_write_enable;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data_in;
  logic [XLEN-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_error, resp_rdata, mem_write_enable, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_error, resp_rdata, mem_write_enable, mem_addr, mem_data_in
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Misaligned low bits are ignored here; trapping (if enabled) happens upstream.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  lsu_size_e       size,
  input  logic            zext,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[1], 4'b0000};

  always_comb begin
    byte_val = 8'(word >> byte_sh);
    half_val = 16'(word >> half_sh);

    case (size)
      BYTE:    load_data = {{(XLEN-8){!zext && byte_val[7]}}, byte_val};
      HALF:    load_data = {{(XLEN-16){!zext && half_val[15]}}, half_val};
      default: load_data = word;
    endcase

    // Replace only the addressed lane of the previously read word
    case (size)
      BYTE:    store_data = (word & ~(XLEN'(32'h0000_00FF) << byte_sh))
                          | ({{(XLEN-8){1'b0}}, wdata[7:0]} << byte_sh);
      HALF:    store_data = (word & ~(XLEN'(32'h0000_FFFF) << half_sh))
                          | ({{(XLEN-16){1'b0}}, wdata[15:0]} << half_sh);
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  lsu_state_e       state_q;
  lsu_state_e       state_d;
  lsu_req_t         req_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  word_q;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  store_data;
  logic             req_error_c;
  logic             accept_c;

  // Classify the incoming request before acceptance
  always_comb begin
    req_error_c = lsu_size_e'(bus.req_size) == ILLEGAL;
`ifdef LSU_MISALIGN_TRAP_EN
    req_error_c = req_error_c || is_misaligned(lsu_size_e'(bus.req_size), bus.req_addr[1:0]);
`endif
  end

  assign accept_c = (state_q == IDLE) && bus.req_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        req_q   <= '{write: bus.req_write, size: lsu_size_e'(bus.req_size),
                     zext: bus.req_unsigned, addr: bus.req_addr, wdata: bus.req_wdata};
        error_q <= req_error_c;
      end
      if (state_q == READ)
        cnt_q <= CNT_W'(READ_LATENCY - 1);
      else if (state_q == WAIT)
        cnt_q <= cnt_q - CNT_W'(1);
      // Memory data is valid on the final wait cycle
      if (state_q == WAIT && cnt_q == '0)
        word_q <= bus.mem_data_out;
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_error       = 1'b0;
    bus.resp_rdata       = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_data_in      = '0;
    bus.mem_addr         = {2'b00, req_q.addr[XLEN-1:2]};

    case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        if (accept_c) begin
          if (req_error_c)
            state_d = DONE;
          else if (bus.req_write && lsu_size_e'(bus.req_size) == WORD)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT:  if (cnt_q == '0) state_d = req_q.write ? WRITE : DONE;
      WRITE: begin
        bus.mem_write_enable = !reset;
        bus.mem_data_in      = reset ? '0 : store_data;
        state_d              = DONE;
      end
      DONE: begin
        bus.resp_valid = !reset;
        bus.resp_error = !reset && error_q;
        bus.resp_rdata = (!reset && !error_q && !req_q.write) ? load_data : '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_byte_lane u_byte_lane (
    .word       (word_q),
    .addr_lo    (req_q.addr[1:0]),
    .size       (req_q.size),
    .zext       (req_q.zext),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model, directed plan cases,
// random traffic, reset-abort and back-to-back scenarios.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned LAT    = 2;
  localparam int unsigned NWORDS = 64;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   errors = 0;
  int   checks = 0;

  lsu_if bus();

  load_store_unit #(.READ_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory with fixed read latency, written by the unit under test
  logic [31:0] mem_words  [NWORDS];
  logic [31:0] init_words [NWORDS];
  logic [31:0] rd_pipe    [LAT];
  logic [7:0]  ref_bytes  [NWORDS*4];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NWORDS; i++) mem_words[i] <= init_words[i];
    end else if (bus.mem_write_enable) begin
      mem_words[bus.mem_addr[5:0]] <= bus.mem_data_in;
    end
    rd_pipe[0] <= mem_words[bus.mem_addr[5:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_data_out = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what the access should do, in bytes, plus its expected timing
  task automatic ref_expect(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic err, output logic [31:0] rdata, output int we_at,
                            output int resp_at, output logic [31:0] wword, output logic [31:0] waddr);
    int nbytes;
    int base;
    int w;
    logic mis;
    logic [31:0] val;
    nbytes = 1 << sz;
    mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    err = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    err = err || mis;
`endif
    rdata = '0; we_at = 0; wword = '0; waddr = addr >> 2; resp_at = 1;
    if (!err) begin
      base = int'(addr[7:0]) & ~(nbytes - 1);
      if (wr) begin
        for (int i = 0; i < nbytes; i++) ref_bytes[base+i] = wd[8*i +: 8];
        w = base & ~3;
        wword = {ref_bytes[w+3], ref_bytes[w+2], ref_bytes[w+1], ref_bytes[w]};
        we_at = (nbytes == 4) ? 1 : 2 + LAT;
        resp_at = we_at + 1;
      end else begin
        val = '0;
        for (int i = 0; i < nbytes; i++) val = val | (32'(ref_bytes[base+i]) << (8*i));
        if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~((32'd1 << (8*nbytes)) - 32'd1);
        rdata = val;
        resp_at = 2 + LAT;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
  endtask

  // One full transaction, sampled each negedge; cycle k is offset from the accept cycle
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic e_err, got_err, ready_seen, din_leak, done;
    logic [31:0] e_rdata, e_wword, e_waddr, we_data, we_addr, got_rdata;
    int e_we, e_resp, we_cnt, we_cyc, resp_cyc;
    ref_expect(wr, sz, uns, addr, wd, e_err, e_rdata, e_we, e_resp, e_wword, e_waddr);
    wait_ready(tag);
    drive(wr, sz, uns, addr, wd);
    done = 1'b0; ready_seen = 1'b0; din_leak = 1'b0;
    we_cnt = 0; we_cyc = 0; resp_cyc = 0; got_err = 1'b0;
    got_rdata = '0; we_data = '0; we_addr = '0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.req_ready) ready_seen = 1'b1;
      if (bus.mem_write_enable) begin
        we_cnt++;
        we_cyc  = k;
        we_data = bus.mem_data_in;
        we_addr = bus.mem_addr;
      end else if (bus.mem_data_in != '0) begin
        din_leak = 1'b1;
      end
      if (bus.resp_valid) begin
        done      = 1'b1;
        resp_cyc  = k;
        got_err   = bus.resp_error;
        got_rdata = bus.resp_rdata;
      end
    end
    check({tag, "_resp_cycle"}, 32'(resp_cyc), 32'(e_resp));
    check({tag, "_error"}, 32'(got_err), 32'(e_err));
    check({tag, "_rdata"}, got_rdata, e_rdata);
    check({tag, "_we_count"}, 32'(we_cnt), (e_we != 0) ? 32'd1 : 32'd0);
    check({tag, "_ready_busy"}, 32'(ready_seen), 32'd0);
    check({tag, "_din_idle"}, 32'(din_leak), 32'd0);
    if (e_we != 0) begin
      check({tag, "_we_cycle"}, 32'(we_cyc), 32'(e_we));
      check({tag, "_we_data"}, we_data, e_wword);
      check({tag, "_we_addr"}, we_addr, e_waddr);
    end
  endtask

  initial begin
    logic e_err;
    logic [31:0] e_r1, e_r2, e_ww, e_wa, d1, d2;
    int e_we, e_resp, r1, r2, acc2, bad;
    logic [1:0] sz;
    int r;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e_err;
    logic [31:0] e_r1, e_r2, e_ww, e_wa, d1, d2;
    int e_we, e_resp, r1, r2, acc2, bad;
    logic [1:0] sz;
    int r;

    reset = 1'b1; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < NWORDS; i++) begin
      init_words[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_bytes[4*i+j] = init_words[i][8*j +: 8];
    end
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_we", 32'(bus.mem_write_enable), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_din", bus.mem_data_in, 32'd0);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Directed plan cases
    run_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    run_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    run_req("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01);
    run_req("lb21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    run_req("lb22", 1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
    run_req("lbu23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
    run_req("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    run_req("sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
    run_req("sb31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA);
    run_req("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF);
    run_req("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    run_req("ld_ill", 1'b0, 2'd3, 1'b0, 32'h50, 32'h0);
    run_req("st_ill", 1'b1, 2'd3, 1'b0, 32'h54, 32'h12345678);
    run_req("lw41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    run_req("sh45", 1'b1, 2'd1, 1'b0, 32'h45, 32'h0000CAFE);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), $urandom);
    end

    // Reset during the WRITE cycle of a byte store: write and response dropped
    wait_ready("rst_wr");
    drive(1'b1, 2'd0, 1'b0, 32'h61, 32'h5A);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_in_write", 32'(bus.mem_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wr_gated", 32'(bus.mem_write_enable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wr_ready", 32'(bus.req_ready), 32'd1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_write_enable) bad++;
    end
    check("rst_wr_quiet", 32'(bad), 32'd0);

    // Reset during WAIT of a load: no response
    wait_ready("rst_wait");
    drive(1'b0, 2'd2, 1'b0, 32'h64, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) bad++;
    end
    check("rst_wait_no_resp", 32'(bad), 32'd0);

    // Back-to-back loads with req_valid held high
    ref_expect(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_err, e_r1, e_we, e_resp, e_ww, e_wa);
    ref_expect(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, e_err, e_r2, e_we, e_resp, e_ww, e_wa);
    wait_ready("b2b");
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    r1 = 0; r2 = 0; acc2 = 0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 30 && r2 == 0; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
      if (acc2 != 0 && k == acc2 + 1) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        if (r1 == 0) begin r1 = k; d1 = bus.resp_rdata; end
        else begin r2 = k; d2 = bus.resp_rdata; end
      end
      if (bus.req_ready && bus.req_valid && acc2 == 0) acc2 = k;
    end
    bus.req_valid = 1'b0;
    check("b2b_resp1_cycle", 32'(r1), 32'(2 + LAT));
    check("b2b_rdata1", d1, e_r1);
    check("b2b_accept2_cycle", 32'(acc2), 32'(r1 + 1));
    check("b2b_resp2_latency", 32'(r2 - acc2), 32'(2 + LAT));
    check("b2b_rdata2", d2, e_r2);

    // Memory image must match the reference byte array
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NWORDS; i++)
      check($sformatf("mem%0d", i), mem_words[i],
            {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
